// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode path: prefix/error byte values,
// event word layout and the decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_ERR0       = 8'h00;
  localparam logic [7:0] PS2_ERR1       = 8'hFF;

  localparam int EVT_CODE_W  = 8;
  localparam int EVT_W       = 10;
  localparam int EVT_BRK_BIT = 9;
  localparam int EVT_EXT_BIT = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PREFIX = 1'b1
  } ps2_state_e;

  function automatic logic [EVT_W-1:0] pack_evt(input logic brk, input logic ext,
                                                input logic [EVT_CODE_W-1:0] code);
    logic [EVT_W-1:0] evt;
    evt = '0;
    evt[EVT_BRK_BIT] = brk;
    evt[EVT_EXT_BIT] = ext;
    evt[EVT_CODE_W-1:0] = code;
    return evt;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO: circular buffer with wrapping pointers and an
// occupancy counter. Head reads as zero while empty.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full, pop_en, push_en;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop_en  = pop & ~empty;
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign push_en = push & (~full | pop_en);
  assign drop    = push & full & ~pop_en;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scancode controller: folds E0/F0 prefixes into single key events,
// queues them and exposes a valid/ready pop port with interrupt and overflow.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   keycode_i,
  input  logic                          keycode_valid_i,
  output logic                          evt_valid_o,
  output logic [EVT_W-1:0]              evt_data_o,
  input  logic                          evt_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
  output logic                          irq_o,
  output logic                          overflow_o,
  input  logic                          clr_overflow_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  ps2_state_e       state_reg, state_next;
  logic             ext_reg, ext_next, brk_reg, brk_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             valid_d_reg, overflow_reg;
  logic             accept, timed_out, ext_cur, brk_cur;
  logic             push, fifo_empty, fifo_drop;
  logic [EVT_W-1:0] push_data;
  logic [7:0]       code_lo, code_hi;

  assign accept  = keycode_valid_i & ~valid_d_reg;
  assign code_lo = keycode_i[7:0];
  assign code_hi = keycode_i[15:8];

  // A prefix that expires on the same edge as a new byte is already gone.
  assign timed_out = (state_reg == ST_PREFIX) && (tmo_cnt_reg == TMO_LAST);
  assign ext_cur   = ext_reg & ~timed_out;
  assign brk_cur   = brk_reg & ~timed_out;

  always_comb begin
    state_next   = state_reg;
    ext_next     = ext_cur;
    brk_next     = brk_cur;
    tmo_cnt_next = tmo_cnt_reg;
    push         = 1'b0;
    push_data    = pack_evt(brk_cur, ext_cur, code_lo);

    if (timed_out) begin
      state_next   = ST_IDLE;
      tmo_cnt_next = '0;
    end else if (state_reg == ST_PREFIX) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end

    if (accept) begin
      tmo_cnt_next = '0;
      if (keycode_i == {PS2_EXT_PREFIX, PS2_ERR0}) begin
        ext_next   = 1'b1;
        state_next = ST_PREFIX;
      end else if (code_lo == PS2_BRK_PREFIX) begin
        brk_next   = 1'b1;
        ext_next   = ext_cur | (code_hi == PS2_EXT_PREFIX);
        state_next = ST_PREFIX;
      end else begin
        push       = (code_lo != PS2_ERR0) && (code_lo != PS2_ERR1);
        ext_next   = 1'b0;
        brk_next   = 1'b0;
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      tmo_cnt_reg  <= '0;
      valid_d_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ext_reg      <= ext_next;
      brk_reg      <= brk_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      valid_d_reg  <= keycode_valid_i;
      if (fifo_drop)           overflow_reg <= 1'b1;
      else if (clr_overflow_i) overflow_reg <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_ready_i),
    .head_data (evt_data_o),
    .count     (evt_count_o),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign evt_valid_o = ~fifo_empty;
  assign irq_o       = ~fifo_empty;
  assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Bench for ps2_scancode_ctrl: directed scenarios plus random byte streams,
// compared every cycle against a queue-based event model.
module tb_ps2_scancode_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keycode_i;
  logic        keycode_valid_i;
  logic        evt_valid_o;
  logic [9:0]  evt_data_o;
  logic        evt_ready_i;
  logic [3:0]  evt_count_o;
  logic        irq_o;
  logic        overflow_o;
  logic        clr_overflow_i;

  ps2_scancode_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .keycode_i       (keycode_i),
    .keycode_valid_i (keycode_valid_i),
    .evt_valid_o     (evt_valid_o),
    .evt_data_o      (evt_data_o),
    .evt_ready_i     (evt_ready_i),
    .evt_count_o     (evt_count_o),
    .irq_o           (irq_o),
    .overflow_o      (overflow_o),
    .clr_overflow_i  (clr_overflow_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_pct  = 0;
  int clr_pct  = 0;
  int n_tx     = 0;

  // Reference model: pending-prefix flags with the edge they were armed on.
  logic [9:0] m_q[$];
  bit m_ovf, m_ext, m_brk, m_pend, m_prev;
  int edge_no, pend_edge;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_pend = 0; m_prev = 0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] w, input logic rdy, input logic clr);
    bit pop, acc, has_evt, set_ovf, was_full;
    logic [9:0] evt;
    edge_no++;
    pop = rdy && (m_q.size() > 0);
    acc = v && !m_prev;
    m_prev = v;
    has_evt = 0;
    evt = '0;
    if (m_pend && (edge_no - pend_edge) >= TIMEOUT) begin
      m_ext = 0; m_brk = 0; m_pend = 0;
    end
    if (acc) begin
      if (w == 16'hE000) begin
        m_ext = 1; m_pend = 1; pend_edge = edge_no;
      end else if (w[7:0] == 8'hF0) begin
        m_brk = 1;
        if (w[15:8] == 8'hE0) m_ext = 1;
        m_pend = 1; pend_edge = edge_no;
      end else begin
        if (w[7:0] != 8'h00 && w[7:0] != 8'hFF) begin
          has_evt = 1;
          evt = {m_brk, m_ext, w[7:0]};
        end
        m_ext = 0; m_brk = 0; m_pend = 0;
      end
    end
    was_full = (m_q.size() == DEPTH);
    set_ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (has_evt) begin
      if (was_full && !pop) set_ovf = 1;
      else m_q.push_back(evt);
    end
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_outputs();
    logic [9:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : 10'h000;
    check_val("evt_valid", evt_valid_o, m_q.size() > 0);
    check_val("irq", irq_o, m_q.size() > 0);
    check_val("evt_count", evt_count_o, m_q.size());
    check_val("evt_data", evt_data_o, exp_data);
    check_val("overflow", overflow_o, m_ovf);
  endtask

  task automatic step(input logic v, input logic [15:0] w, input logic rdy, input logic clr);
    keycode_valid_i = v;
    keycode_i       = w;
    evt_ready_i     = rdy;
    clr_overflow_i  = clr;
    @(posedge clk);
    model_edge(v, w, rdy, clr);
    #1;
    check_outputs();
  endtask

  task automatic rand_step(input logic v, input logic [15:0] w);
    logic rdy, clr;
    rdy = ($urandom_range(0, 99) < rdy_pct);
    clr = ($urandom_range(0, 99) < clr_pct);
    step(v, w, rdy, clr);
  endtask

  task automatic send(input logic [15:0] w, input int hold, input int gap);
    for (int i = 0; i < hold; i++) rand_step(1'b1, w);
    for (int i = 0; i < gap; i++)  rand_step(1'b0, w);
    n_tx++;
    $display("tx %0d: word=%04h hold=%0d gap=%0d count=%0d", n_tx, w, hold, gap, evt_count_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rand_step(1'b0, 16'h0000);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    $display("reset pulse applied");
  endtask

  initial begin
    logic [15:0] w;
    int r, hold, gap;
    edge_no = 0; pend_edge = 0;
    rst_n = 1'b0;
    keycode_i = '0; keycode_valid_i = 1'b0;
    evt_ready_i = 1'b0; clr_overflow_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // make code, extended break, pop them
    send(16'h001C, 2, 3);
    send(16'hE000, 1, 1);
    send(16'hE0F0, 1, 1);
    send(16'h0075, 1, 3);
    rdy_pct = 100; idle(4); rdy_pct = 0;

    // prefix timeout: one cycle inside the window, then exactly at expiry
    send(16'h00F0, 1, TIMEOUT - 2);
    send(16'h001C, 1, 2);
    send(16'h00F0, 1, TIMEOUT - 1);
    send(16'h001C, 1, 2);
    rdy_pct = 100; idle(4); rdy_pct = 0;

    // overflow and clear
    for (int i = 0; i < 9; i++) send(16'(8'h10 + i), 1, 1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // simultaneous push and pop on a full FIFO
    step(1'b1, 16'h0033, 1'b1, 1'b0);
    step(1'b0, 16'h0033, 1'b0, 1'b0);
    rdy_pct = 100; idle(10); rdy_pct = 0;

    // reset while a prefix is pending and events are queued
    send(16'h0021, 1, 1);
    send(16'hE000, 1, 2);
    pulse_reset();
    send(16'h001C, 1, 3);
    rdy_pct = 100; idle(3);

    // random streams
    for (int it = 0; it < 400; it++) begin
      rdy_pct = (it < 150) ? 15 : 60;
      clr_pct = 5;
      r = $urandom_range(0, 9);
      case (r)
        0: w = 16'hE000;
        1: w = 16'hE0F0;
        2: w = 16'h00F0;
        3: w = {8'($urandom), (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF)};
        4: w = {8'hE0, 8'($urandom)};
        default: w = {(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00), 8'($urandom)};
      endcase
      hold = $urandom_range(1, 3);
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 1)
                                        : $urandom_range(0, 3);
      send(w, hold, gap);
      if (it == 250) pulse_reset();
    end
    rdy_pct = 100; clr_pct = 0;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
